// File: rtl/audio_seq_pkg.sv
// audio_seq_pkg: shared state encoding and address defaults for the audio sample sequencer
package audio_seq_pkg;
   localparam int ADDR_BITS_DEF = 23;
   localparam logic [22:0] LAST_ADDR_DEF = 23'h7FFFF;
   typedef enum logic [3:0] {
      IDLE, REQ, WAIT_DATA, OUT_LO, HOLD_LO, GAP, OUT_HI, HOLD_HI, ADVANCE
   } seq_state_t;
endpackage

// File: rtl/audio_sample_sequencer_if.sv
// audio_sample_sequencer_if: flash read bus between the sequencer (master) and the flash controller (slave)
// Signals: flash_read/flash_address request, flash_waitrequest stall, flash_readdata/flash_readdatavalid return
interface audio_sample_sequencer_if
   import audio_seq_pkg::*;
#(
   parameter int ADDR_BITS = ADDR_BITS_DEF
);
   logic                 flash_read;
   logic [ADDR_BITS-1:0] flash_address;
   logic                 flash_waitrequest;
   logic [31:0]          flash_readdata;
   logic                 flash_readdatavalid;
   modport master (
      output flash_read, flash_address,
      input  flash_waitrequest, flash_readdata, flash_readdatavalid
   );
   modport slave (
      input  flash_read, flash_address,
      output flash_waitrequest, flash_readdata, flash_readdatavalid
   );
endinterface

// File: rtl/addr_stepper.sv
// addr_stepper: next flash word address with wrap between 0 and LAST_ADDR
// Ports: i_addr current address, i_reverse direction, i_restart reload start, i_step advance one word, o_next result
module addr_stepper
   import audio_seq_pkg::*;
#(
   parameter int ADDR_BITS = ADDR_BITS_DEF,
   parameter logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(LAST_ADDR_DEF)
) (
   input  logic [ADDR_BITS-1:0] i_addr,
   input  logic                 i_reverse,
   input  logic                 i_restart,
   input  logic                 i_step,
   output logic [ADDR_BITS-1:0] o_next
);
   // restart outranks a coincident step so the reload is never lost
   always_comb
      o_next = i_restart ? (i_reverse ? LAST_ADDR : '0) :
               !i_step   ? i_addr :
               i_reverse ? (i_addr == '0 ? LAST_ADDR : i_addr - 1'b1) :
                           (i_addr == LAST_ADDR ? '0 : i_addr + 1'b1);
endmodule

// File: rtl/audio_sample_sequencer.sv
// audio_sample_sequencer: fetches 32-bit flash words and plays each as two 16-bit samples paced by an external timer
// Ports: CLOCK_50M clock, reset_n async active-low reset, enable/reverse/restart playback controls,
//        wait_flag/wait_done timer handshake, sample_out current sample, flash master side of the flash bus
module audio_sample_sequencer
   import audio_seq_pkg::*;
#(
   parameter int ADDR_BITS = ADDR_BITS_DEF,
   parameter logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(LAST_ADDR_DEF)
) (
   input  logic                     CLOCK_50M,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     reverse,
   input  logic                     restart,
   input  logic                     wait_done,
   output logic                     wait_flag,
   output logic [15:0]              sample_out,
   audio_sample_sequencer_if.master flash
);
   seq_state_t           r_state, w_next;
   logic [ADDR_BITS-1:0] r_addr, w_addr_next;
   logic [31:0]          r_word;
   logic [15:0]          r_sample;
   logic                 r_read, r_wait_flag, w_step;
   assign w_step = r_state == ADVANCE;
   addr_stepper #(.ADDR_BITS(ADDR_BITS), .LAST_ADDR(LAST_ADDR)) u_stepper (
      .i_addr    (r_addr),
      .i_reverse (reverse),
      .i_restart (restart),
      .i_step    (w_step),
      .o_next    (w_addr_next)
   );
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      w_next = enable ? REQ : IDLE;
         REQ:       w_next = flash.flash_waitrequest ? REQ : WAIT_DATA;
         WAIT_DATA: w_next = flash.flash_readdatavalid ? OUT_LO : WAIT_DATA;
         OUT_LO:    w_next = HOLD_LO;
         HOLD_LO:   w_next = wait_done ? GAP : HOLD_LO;
         GAP:       w_next = OUT_HI;
         OUT_HI:    w_next = HOLD_HI;
         HOLD_HI:   w_next = wait_done ? ADVANCE : HOLD_HI;
         ADVANCE:   w_next = enable ? REQ : IDLE;
         default:   w_next = IDLE;
      endcase
   end
   // wait_flag drops only for GAP between halves so the timer clears its completed flag
   always_ff @(posedge CLOCK_50M or negedge reset_n)
      if (!reset_n) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_word      <= '0;
         r_sample    <= '0;
         r_read      <= 1'b0;
         r_wait_flag <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_addr      <= w_addr_next;
         r_read      <= w_next == REQ;
         r_wait_flag <= w_next == HOLD_LO || w_next == OUT_HI || w_next == HOLD_HI;
         if (r_state == WAIT_DATA && flash.flash_readdatavalid) r_word <= flash.flash_readdata;
         if (r_state == OUT_LO) r_sample <= r_word[15:0];
         if (r_state == OUT_HI) r_sample <= r_word[31:16];
      end
   assign flash.flash_read    = r_read;
   assign flash.flash_address = r_addr;
   assign wait_flag           = r_wait_flag;
   assign sample_out          = r_sample;
endmodule

// File: tb/tb_audio_sample_sequencer.sv
// tb_audio_sample_sequencer: randomized flash/timer environment with a word-level playback model
module tb_audio_sample_sequencer;
   import audio_seq_pkg::*;
   localparam int ADDR_BITS = 23;
   localparam int unsigned LAST = 'h7FFFF;
   logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b0, reverse = 1'b0, restart = 1'b0;
   logic        wait_done, wait_flag;
   logic [15:0] sample_out;
   audio_sample_sequencer_if #(.ADDR_BITS(ADDR_BITS)) fl ();
   audio_sample_sequencer dut (
      .CLOCK_50M  (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .reverse    (reverse),
      .restart    (restart),
      .wait_done  (wait_done),
      .wait_flag  (wait_flag),
      .sample_out (sample_out),
      .flash      (fl.master)
   );
   always #5 clk = ~clk;
   int n_tests = 0, n_fail = 0;
   int r_div = 3, cfg_stall = 0, cfg_lat = 1;
   int lo_ev = 0, hi_ev = 0, acc_ev = 0, quiet = 0, cyc = 0, lo_cyc = 0;
   int lowcnt = 0, last_low = 0, stall_left = 0, lat_left = 0, t_cnt = 0;
   logic in_req = 1'b0, just_acc = 1'b0;
   logic [22:0] exp_addr = '0, cur_addr = '0, req_addr = '0, lat_addr = '0;
   logic [15:0] prev = '0;
   logic [16:0] q[$];
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // flash contents: word 0 is fixed; other words alternate sample parity so every update is visible
   function automatic logic [31:0] word_of(input logic [22:0] a);
      logic [31:0] h;
      h = 32'(a) * 32'h9E3779B1 ^ 32'h5A5A0F0F;
      return a == '0 ? 32'hBEEF_1234 : {1'b1, h[30:17], 1'b0, 1'b0, h[14:1], 1'b1};
   endfunction
   function automatic logic [22:0] step_addr(input logic [22:0] a, input logic rev);
      int unsigned n, ua;
      n  = LAST + 1;
      ua = 32'(a);
      return 23'(rev ? (ua + n - 1) % n : (ua + 1) % n);
   endfunction
   // downstream sample-period timer: completed rises after r_div cycles of flag, clears while flag is low
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         t_cnt     <= 0;
         wait_done <= 1'b0;
      end else if (!wait_flag) begin
         t_cnt     <= 0;
         wait_done <= 1'b0;
      end else begin
         t_cnt <= t_cnt + 1;
         if (t_cnt >= r_div - 2) wait_done <= 1'b1;
      end
   initial begin
      logic [16:0] e;
      logic [31:0] w;
      fl.flash_waitrequest   = 1'b0;
      fl.flash_readdata      = '0;
      fl.flash_readdatavalid = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset_n) begin
            q.delete();
            prev     = '0;
            exp_addr = '0;
            lowcnt   = 0;
            last_low = 0;
            in_req   = 1'b0;
            just_acc = 1'b0;
            quiet    = 0;
         end else begin
            if (!wait_flag) lowcnt++;
            else begin
               if (lowcnt != 0) last_low = lowcnt;
               lowcnt = 0;
            end
            if (sample_out !== prev) begin
               if (q.size() == 0) chk("spurious_sample", sample_out, prev);
               else begin
                  e = q.pop_front();
                  chk(e[16] ? "sample_hi" : "sample_lo", sample_out, e[15:0]);
                  if (e[16]) begin
                     chk("lo_hold_cycles", cyc - lo_cyc, r_div + 2);
                     chk("gap_low_cycles", last_low, 1);
                     hi_ev++;
                     exp_addr = step_addr(cur_addr, reverse);
                  end else begin
                     lo_cyc = cyc;
                     lo_ev++;
                  end
               end
               prev  = sample_out;
               quiet = 0;
            end else if (fl.flash_read || wait_flag) quiet = 0;
            else quiet++;
         end
         fl.flash_readdatavalid = 1'b0;
         if (lat_left > 0) begin
            lat_left--;
            if (lat_left == 0) begin
               w = word_of(lat_addr);
               fl.flash_readdata      = w;
               fl.flash_readdatavalid = 1'b1;
               q.push_back({1'b0, w[15:0]});
               q.push_back({1'b1, w[31:16]});
            end
         end
         if (just_acc) begin
            chk("read_drop", fl.flash_read, 0);
            just_acc = 1'b0;
         end
         if (reset_n && in_req && !fl.flash_read) begin
            chk("read_held", 0, 1);
            in_req = 1'b0;
         end
         if (reset_n && fl.flash_read) begin
            if (!in_req) begin
               in_req     = 1'b1;
               stall_left = cfg_stall;
               req_addr   = fl.flash_address;
            end else chk("addr_stable", fl.flash_address, req_addr);
            if (stall_left > 0) begin
               fl.flash_waitrequest = 1'b1;
               stall_left--;
            end else begin
               fl.flash_waitrequest = 1'b0;
               in_req   = 1'b0;
               just_acc = 1'b1;
               chk("req_addr", fl.flash_address, exp_addr);
               cur_addr = exp_addr;
               lat_addr = fl.flash_address;
               lat_left = cfg_lat;
               acc_ev++;
            end
         end else fl.flash_waitrequest = 1'b0;
      end
   end
   task automatic pulse_restart();
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart  = 1'b0;
      exp_addr = reverse ? 23'(LAST) : '0;
      chk("restart_addr", fl.flash_address, exp_addr);
   endtask
   // play n words, dropping enable right after the last word's first sample so it parks
   task automatic play(input int n);
      int lo0, hi0, k;
      lo0 = lo_ev;
      hi0 = hi_ev;
      k   = 0;
      enable = 1'b1;
      while (lo_ev < lo0 + n && k < 400 * n) begin
         @(negedge clk);
         k++;
      end
      enable = 1'b0;
      k = 0;
      while (quiet < 20 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      chk("words_played", hi_ev - hi0, n);
      chk("park_addr", fl.flash_address, exp_addr);
   endtask
   initial begin
      int k, acc0;
      cfg_stall = 5;
      cfg_lat   = 7;
      repeat (3) @(negedge clk);
      chk("rst_read", fl.flash_read, 0);
      chk("rst_addr", fl.flash_address, 0);
      chk("rst_wait_flag", wait_flag, 0);
      chk("rst_sample", sample_out, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      play(2);
      chk("fwd_park_addr", fl.flash_address, 2);
      reverse = 1'b1;
      pulse_restart();
      reverse = 1'b0;
      play(1);
      chk("wrap_fwd_addr", fl.flash_address, 0);
      reverse = 1'b1;
      play(1);
      chk("wrap_rev_addr", fl.flash_address, LAST);
      reverse   = 1'b0;
      r_div     = 2;
      cfg_stall = 0;
      cfg_lat   = 1;
      pulse_restart();
      play(256);
      chk("addr_0x100", fl.flash_address, 'h100);
      pulse_restart();
      chk("restart_0x100", fl.flash_address, 0);
      play(1);
      for (int i = 0; i < 24; i++) begin
         r_div     = $urandom_range(2, 5);
         cfg_stall = $urandom_range(0, 4);
         cfg_lat   = $urandom_range(1, 8);
         reverse   = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) pulse_restart();
         play($urandom_range(1, 4));
      end
      cfg_stall = 0;
      cfg_lat   = 8;
      acc0      = acc_ev;
      k         = 0;
      enable    = 1'b1;
      while (acc_ev == acc0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("wait_data_reached", acc_ev - acc0, 1);
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async_read", fl.flash_read, 0);
      chk("async_addr", fl.flash_address, 0);
      chk("async_wait_flag", wait_flag, 0);
      chk("async_sample", sample_out, 0);
      enable = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("stray_valid_sample", sample_out, 0);
      chk("stray_valid_read", fl.flash_read, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
